// File: rtl/fres_pkg.sv
// rtl/fres_pkg.sv - shared types and constants for the FPU result writeback stage
package fres_pkg;

  // Width of a packed, NaN-boxed FP result
  localparam int FRES_FLEN = 64;

  // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} exception flag vector
  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  // One buffered result: value, exception flags, destination register
  typedef struct packed {
    logic [FRES_FLEN-1:0] res;
    logic [4:0]           flags;
    logic [4:0]           rd;
  } fres_entry_t;

  // Sticky accrual of exception flags into an accumulator
  function automatic logic [4:0] fres_accrue(input logic [4:0] acc, input logic [4:0] add);
    return acc | add;
  endfunction

endpackage

// File: rtl/fres_fifo.sv
// rtl/fres_fifo.sv - DEPTH-entry circular buffer of fres_entry_t with flush
module fres_fifo
  import fres_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  fres_entry_t wdata_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output fres_entry_t rdata_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fres_entry_t       mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // Never overrun or underrun, whatever the caller asks for
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/count state and entry storage; storage clears on reset so the head reads 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fres_wbstage.sv
// rtl/fres_wbstage.sv - FPU result writeback buffer with sticky fflags; optional FRES_BYPASS_EN empty-buffer bypass
module fres_wbstage
  import fres_pkg::*;
#(
  parameter int FLEN  = FRES_FLEN,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            InValid,
  output logic            InReady,
  input  logic [FLEN-1:0] InRes,
  input  logic [4:0]      InFlags,
  input  logic [4:0]      InRd,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [FLEN-1:0] OutRes,
  output logic [4:0]      OutRd,
  input  logic            Flush,
  input  logic            FflagsWrEn,
  input  logic [4:0]      FflagsWrData,
  output logic [4:0]      FFlags
);

  fres_entry_t in_entry;
  fres_entry_t fifo_head;
  fres_entry_t head_entry;
  logic        fifo_full;
  logic        fifo_empty;
  logic        bypass;
  logic        commit;
  logic        push;
  logic        pop;
  logic [4:0]  commit_flags;
  logic [4:0]  fflags_q, fflags_d;

  assign in_entry = '{res: InRes, flags: InFlags, rd: InRd};

`ifdef FRES_BYPASS_EN
  // An empty buffer lets a fresh result straight through to the register file
  assign bypass = fifo_empty & InValid & ~Flush;
`else
  assign bypass = 1'b0;
`endif

  // Ready depends only on buffer state, never on OutReady
  assign InReady    = ~fifo_full;
  assign OutValid   = ~Flush & (~fifo_empty | bypass);
  assign head_entry = bypass ? in_entry : fifo_head;
  assign OutRes     = head_entry.res;
  assign OutRd      = head_entry.rd;

  assign commit       = OutValid & OutReady;
  // A bypassed result that commits immediately never occupies a slot
  assign push         = InValid & InReady & ~Flush & ~(bypass & OutReady);
  assign pop          = commit & ~bypass;
  assign commit_flags = commit ? head_entry.flags : 5'b0;

  fres_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (push),
    .wdata_i (in_entry),
    .pop_i   (pop),
    .flush_i (Flush),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // CSR write replaces the accumulator but a same-cycle commit still accrues
  always_comb begin
    fflags_d = fflags_q;
    if (FflagsWrEn) fflags_d = fres_accrue(FflagsWrData, commit_flags);
    else            fflags_d = fres_accrue(fflags_q, commit_flags);
  end

  // Sticky accrued exception flags; flush leaves them alone
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fflags_q <= 5'b0;
    else          fflags_q <= fflags_d;
  end

  assign FFlags = fflags_q;

endmodule

// File: tb/tb_fres_wbstage.sv
// tb/tb_fres_wbstage.sv - scoreboard bench for fres_wbstage
module tb_fres_wbstage;

  localparam int FLEN  = 64;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  flags;
    logic [4:0]  rd;
  } exp_t;

  logic            clk;
  logic            reset_n;
  logic            InValid;
  logic            InReady;
  logic [FLEN-1:0] InRes;
  logic [4:0]      InFlags;
  logic [4:0]      InRd;
  logic            OutValid;
  logic            OutReady;
  logic [FLEN-1:0] OutRes;
  logic [4:0]      OutRd;
  logic            Flush;
  logic            FflagsWrEn;
  logic [4:0]      FflagsWrData;
  logic [4:0]      FFlags;

  fres_wbstage #(.FLEN(FLEN), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .InValid      (InValid),
    .InReady      (InReady),
    .InRes        (InRes),
    .InFlags      (InFlags),
    .InRd         (InRd),
    .OutValid     (OutValid),
    .OutReady     (OutReady),
    .OutRes       (OutRes),
    .OutRd        (OutRd),
    .Flush        (Flush),
    .FflagsWrEn   (FflagsWrEn),
    .FflagsWrData (FflagsWrData),
    .FFlags       (FFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: entries waiting to reach the register file, oldest first
  exp_t       q[$];
  logic [4:0] m_fflags  = 5'b0;
  logic       exp_ready = 1'b1;
  logic       exp_valid = 1'b0;
  exp_t       mon_e;
  logic [4:0] mon_cf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and record what the model expects of it
  task automatic cyc(input logic v, input logic [63:0] r, input logic [4:0] f,
                     input logic [4:0] d, input logic ordy, input logic fl,
                     input logic we, input logic [4:0] wd);
    int sz;
    @(posedge clk); #1;
    InValid = v; InRes = r; InFlags = f; InRd = d;
    OutReady = ordy; Flush = fl; FflagsWrEn = we; FflagsWrData = wd;
    sz = q.size();
    exp_ready = (sz < DEPTH);
`ifdef FRES_BYPASS_EN
    exp_valid = !fl && (sz > 0 || v);
`else
    exp_valid = !fl && (sz > 0);
`endif
    if (v && exp_ready && !fl) q.push_back('{res: r, flags: f, rd: d});
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 64'h0, 5'h0, 5'h0, ordy, 1'b0, 1'b0, 5'h0);
  endtask

  // Monitor: compare handshake, head contents and flags; retire committed entries
  always @(negedge clk) begin
    if (reset_n) begin
      chk("in_ready", {63'b0, InReady}, {63'b0, exp_ready});
      chk("out_valid", {63'b0, OutValid}, {63'b0, exp_valid});
      chk("fflags", {59'b0, FFlags}, {59'b0, m_fflags});
      mon_cf = 5'b0;
      if (exp_valid) begin
        if (q.size() == 0) begin
          chk("model_underrun", 64'd0, 64'd1);
        end else begin
          mon_e = q[0];
          chk("out_res", OutRes, mon_e.res);
          chk("out_rd", {59'b0, OutRd}, {59'b0, mon_e.rd});
          if (OutReady) begin
            mon_cf = mon_e.flags;
            void'(q.pop_front());
          end
        end
      end
      m_fflags = FflagsWrEn ? (FflagsWrData | mon_cf) : (m_fflags | mon_cf);
      if (Flush) q.delete();
    end
  end

  initial begin
    reset_n = 1'b0;
    InValid = 1'b0; InRes = '0; InFlags = '0; InRd = '0;
    OutReady = 1'b0; Flush = 1'b0; FflagsWrEn = 1'b0; FflagsWrData = '0;

    // Reset values
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", {63'b0, OutValid}, 64'd0);
    chk("rst_in_ready", {63'b0, InReady}, 64'd1);
    chk("rst_fflags", {59'b0, FFlags}, 64'd0);
    chk("rst_out_res", OutRes, 64'd0);
    chk("rst_out_rd", {59'b0, OutRd}, 64'd0);
    @(negedge clk); #1 reset_n = 1'b1;

    // Single result through the stage
    cyc(1'b1, 64'hFFFFFFFF_3F800000, 5'b00001, 5'd3, 1'b1, 1'b0, 1'b0, 5'h0);
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("single_fflags", {59'b0, FFlags}, 64'd1);

    // CSR write colliding with a commit
    cyc(1'b1, 64'h1234, 5'b10000, 5'd7, 1'b0, 1'b0, 1'b0, 5'h0);
    cyc(1'b0, 64'h0, 5'h0, 5'h0, 1'b1, 1'b0, 1'b1, 5'b00100);
    idle(1'b1);
    @(negedge clk);
    chk("csr_collision", {59'b0, FFlags}, 64'h14);

    // Backpressure: only DEPTH entries fit
    cyc(1'b1, 64'hA0, 5'b00010, 5'd1, 1'b0, 1'b0, 1'b0, 5'h0);
    cyc(1'b1, 64'hA1, 5'b00100, 5'd2, 1'b0, 1'b0, 1'b0, 5'h0);
    cyc(1'b1, 64'hA2, 5'b01000, 5'd3, 1'b0, 1'b0, 1'b0, 5'h0);
    @(negedge clk);
    chk("bp_in_ready", {63'b0, InReady}, 64'd0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush with two flagged entries and a third offered; flags must not accrue
    cyc(1'b0, 64'h0, 5'h0, 5'h0, 1'b0, 1'b0, 1'b1, 5'b00000);
    cyc(1'b1, 64'hB0, 5'b10000, 5'd4, 1'b0, 1'b0, 1'b0, 5'h0);
    cyc(1'b1, 64'hB1, 5'b10000, 5'd5, 1'b0, 1'b0, 1'b0, 5'h0);
    cyc(1'b1, 64'hB2, 5'b10000, 5'd6, 1'b1, 1'b1, 1'b0, 5'h0);
    idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("flush_fflags", {59'b0, FFlags}, 64'd0);

    // Random traffic with varying backpressure, flushes and CSR writes
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)),
          (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
          $urandom_range(0, 24) == 0, $urandom_range(0, 11) == 0,
          5'($urandom_range(0, 31)));
    end

    // Async reset while results are waiting
    cyc(1'b1, 64'hC0, 5'b00011, 5'd9, 1'b0, 1'b0, 1'b0, 5'h0);
    cyc(1'b1, 64'hC1, 5'b00011, 5'd10, 1'b0, 1'b0, 1'b0, 5'h0);
    @(posedge clk); #1;
    InValid = 1'b0; OutReady = 1'b0; Flush = 1'b0; FflagsWrEn = 1'b0;
    #1;
    chk("pre_reset_out_valid", {63'b0, OutValid}, 64'd1);
    chk("pre_reset_fflags", {59'b0, FFlags}, {59'b0, m_fflags});
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", {63'b0, OutValid}, 64'd0);
    chk("async_fflags", {59'b0, FFlags}, 64'd0);
    chk("async_in_ready", {63'b0, InReady}, 64'd1);
    q.delete();
    m_fflags  = 5'b0;
    exp_valid = 1'b0;
    exp_ready = 1'b1;
    @(negedge clk); #1 reset_n = 1'b1;

    // Short traffic after reset, then drain
    for (int i = 0; i < 40; i++) begin
      cyc($urandom_range(0, 1) != 0, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31)), $urandom_range(0, 2) != 0, 1'b0, 1'b0, 5'h0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fres_wbstage.md
# fres_wbstage

FPU result writeback stage sitting directly downstream of the round-to-integer unit and the other FPU result producers. It buffers each packed, NaN-boxed result with its exception flags and destination register in a small FIFO with a valid/ready handshake. Its sticky accrued-flags register (fflags: NV, DZ, OF, UF, NX) accumulates flags only when a result actually commits to the register file. Software reads and writes this register through a CSR port.

## Interface
- FLEN, 64, result width, matching the packed FP result width
- DEPTH, 2, buffer entries; must be a power of two, ≥2
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- InValid  in  1  producer has a result
- InReady  out  1  stage can accept; `InReady = ~full`, registered-state only, no path from OutReady
- InRes  in  FLEN  packed result, for example the output of the round-to-integer unit
- InFlags  in  5  {NV,DZ,OF,UF,NX}; round-to-integer drives {FRoundNV,0,0,0,FRoundNX}
- InRd  in  5  destination FP register
- OutValid  out  1  head entry valid
- OutReady  in  1  register-file write port free
- OutRes  out  FLEN  head result
- OutRd  out  5  head destination
- Flush  in  1  discard all buffered and incoming entries
- FflagsWrEn  in  1  CSR write to fflags
- FflagsWrData  in  5  CSR write data
- FFlags  out  5  accrued flags register

## Operation
- Accept on `InValid & InReady`: the entry {InRes, InFlags, InRd} is written at the tail, and the tail pointer wraps modulo DEPTH.
- Commit on `OutValid & OutReady`: the head pops, and the head's flags are ORed into FFlags.
- Occupancy counter is 0..DEPTH:
  - full = count==DEPTH; empty = count==0.
  - Simultaneous accept and commit leaves count unchanged. This is legal when full only if the commit happens; InReady is still 0 that cycle, so no accept occurs.
- FFlags next-state, in priority order:
  - Flush does not clear FFlags.
  - FflagsWrEn: FFlags ← FflagsWrData | committed flags. The same-cycle commit is never lost.
  - Otherwise: FFlags ← FFlags | committed flags.
- Flush:
  - Next cycle count=0 and pointers reset to 0.
  - An input offered in the flush cycle is dropped.
  - OutValid is forced to 0 in the flush cycle, so no commit occurs and no flags accrue.
- Flags of discarded entries never reach FFlags.

## Timing
- Reset values: OutValid=0, InReady=1, FFlags=5'b0, pointers=0, count=0; OutRes and OutRd are 0.
- Latency (non-bypass): an entry accepted at edge N is visible with OutValid=1 after edge N.
- Throughput: one result per cycle sustained when OutReady stays 1.
- Backpressure: with OutReady=0, exactly DEPTH entries are accepted, then InReady=0 until the first commit edge.
- OutRes and OutRd stay stable while `OutValid & ~OutReady`.
- FFlags updates at the commit edge; it is visible the cycle after the commit.
- Reset asserted mid-operation: all entries are lost immediately (asynchronously) and outputs return to their reset values.

## Configuration
- FRES_BYPASS_EN defined:
  - When empty, `InValid` is true and Flush is not asserted, the input drives the outputs combinationally: OutValid=1, OutRes=InRes, OutRd=InRd.
  - If OutReady is also 1, the entry commits in the same cycle without being written, and its flags accrue at that edge.
  - If OutReady=0, the entry is written normally.
- FRES_BYPASS_EN not defined: OutValid depends only on buffer state, giving a fixed 1-cycle latency.

## Structure
- fres_pkg contains:
  - typedef `fres_entry_t` {res[FLEN-1:0], flags[4:0], rd[4:0]}.
  - Flag index constants FLG_NV=4, FLG_DZ=3, FLG_OF=2, FLG_UF=1, FLG_NX=0.
- One sub-module, fres_fifo:
  - Generic DEPTH-entry circular buffer of fres_entry_t.
  - Handles push/pop, count, full/empty and flush.
- Top level contains the handshake, the bypass logic, and the FFlags register.

## Test plan
- Reset, single result: push InRes=64'hFFFFFFFF_3F800000, InFlags=5'b00001, InRd=3 with OutReady=1 → OutValid=1 one cycle later with matching OutRes/OutRd; FFlags=5'b00001 the cycle after the commit.
- Backpressure with DEPTH=2 and OutReady=0: three back-to-back pushes → first two accepted, InReady=0 on the third. Then OutReady=1 → entries emerge in order, and InReady returns to 1 the cycle after the first commit.
- CSR collision: FFlags=5'b00001, commit with flags 5'b10000 in the same cycle as FflagsWrEn with data 5'b00100 → FFlags=5'b10100.
- Flush with two entries holding flags 5'b10000 and a third offered → next cycle OutValid=0, InReady=1, FFlags unchanged, and no dropped entry ever appears on the output.
- Async reset mid-stream: assert reset_n=0 between clock edges while OutValid=1 → OutValid=0 and FFlags=0 immediately, without waiting for a clock edge.
- FRES_BYPASS_EN, empty buffer, InValid=1, OutReady=1 → same-cycle OutValid=1, OutRes=InRes, and count stays 0. Without the macro → OutValid asserts one cycle later.
